instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage for the 16-bit CPU. It sits directly upstream of the opcode decoder. It owns the program counter and issues word reads to instruction memory, one outstanding at a time. Fetched words go into a small FIFO and are presented to the decoder with a valid/ready handshake. It also handles branch redirects, including discarding a read that is in flight when the redirect arrives.

## Interface
Parameters:
- PC_WIDTH, 8, program counter / word-address width
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  read request, held high until acknowledged
- imem_addr  output  PC_WIDTH  word address, stable while imem_req is high
- imem_ack  input  1  one-cycle acknowledge, valid only while imem_req is high
- imem_rdata  input  16  instruction word, valid when imem_ack is high
- branch_en  input  1  one-cycle redirect strobe
- branch_target  input  PC_WIDTH  new PC, sampled when branch_en is high
- instr  output  16  FIFO head word, feeds decoder instr[15:0]
- instr_pc  output  PC_WIDTH  address of the word on instr
- instr_valid  output  1  FIFO not empty
- instr_ready  input  1  decoder accepts; pop when instr_valid && instr_ready

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its data is kept.
  - DROP: request outstanding; its data is discarded.
- imem_req = (state != IDLE), registered. imem_addr = address of the outstanding request.
- Space rule: a new request may issue at an edge only if next_count + 1 <= FIFO_DEPTH.
  - next_count includes the push and pop happening at that edge.
- IDLE -> WAIT when the space rule holds. imem_addr <= pc, pc <= pc + 1.
- WAIT, ack high:
  - Push {imem_rdata, imem_addr}.
  - If the space rule holds, stay in WAIT with the next pc (back-to-back). Otherwise go to IDLE.
- WAIT, ack low: hold imem_req and imem_addr.
- PC arithmetic: pc + 1 modulo 2^PC_WIDTH; 2^PC_WIDTH-1 wraps to 0 with no flag.
- Redirect (branch_en high at an edge); branch has priority over push:
  - FIFO is flushed: count <= 0, any same-edge push is dropped.
  - A same-edge pop still counts as accepted by the decoder.
  - pc <= branch_target.
  - In WAIT with ack low: go to DROP; imem_addr is kept at the old address until the ack.
  - In WAIT with ack high: data is discarded; go to WAIT with imem_addr <= branch_target.
  - In IDLE: go to WAIT with imem_addr <= branch_target.
  - In DROP: stay in DROP; only the latest target is kept.
- DROP, ack high: discard data, then go to WAIT with the redirected pc.
- FIFO: full when count == FIFO_DEPTH. A push and a pop at the same edge leave count unchanged. A pop on empty cannot occur (instr_valid is low).

## Timing
- Reset values (asynchronous): state IDLE, pc RESET_PC, imem_req 0, imem_addr RESET_PC, count 0, instr_valid 0, instr 0, instr_pc 0.
- First request: imem_req rises after the first clock edge after rst deasserts.
- Fetch latency: ack sampled at edge E means instr_valid is high after E. Data never passes combinationally from imem_rdata to instr.
- Throughput with zero-wait-state memory (ack in the first req cycle): 1 word/cycle. This holds when the decoder is always ready and FIFO_DEPTH >= 2.
- Redirect: instr_valid is low in the cycle after the branch_en edge.
  - First target word is valid 1 cycle after its ack.
  - If a request was in flight (DROP), the target request issues only after the stale ack.
- rst asserted mid-request: everything returns to reset values immediately. Memory must tolerate imem_req dropping without an ack.

## Configuration
- FETCH_COUNT_EN defined:
  - Adds output fetch_count, 16 bits, reset 0.
  - Increments on every decoder pop (instr_valid && instr_ready), including a pop on a branch edge.
  - Wraps 0xFFFF -> 0.
- FETCH_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst 3 cycles -> all outputs at reset values. Release -> imem_req=1, imem_addr=0 the next cycle.
- Streaming: zero-wait memory returning rdata = 0x1000+addr, instr_ready=1 -> instr 0x1000, 0x1001, 0x1002… on consecutive cycles, with instr_pc matching.
- Backpressure: instr_ready=0, FIFO_DEPTH=2 -> exactly 2 words buffered, imem_req=0, and no address skipped once ready=1.
- Redirect in flight: ack delayed 3 cycles, branch_en with target 0x40 in cycle 1 ->
  - stale word discarded, instr_valid=0;
  - next imem_addr is 0x40;
  - first delivered instr_pc is 0x40.
- Simultaneous: branch_en, ack and pop at the same edge -> popped word counted, acked word dropped, count=0, next imem_addr is the target.
- Wrap / counter: RESET_PC=0xFE, PC_WIDTH=8 ->
  - instr_pc sequence is 0xFE, 0xFF, 0x00;
  - with FETCH_COUNT_EN, fetch_count=3 after three pops.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bundles the instruction-memory read port, the branch
// redirect strobe and the decoder-facing valid/ready port of the fetch stage.
// master = fetch unit side, slave = memory/decoder/branch side.
interface instr_fetch_unit_if #(
   parameter int PC_WIDTH = 8
);
   // instruction memory read port
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_ack;
   logic [15:0]         imem_rdata;

   // redirect strobe from the execute side
   logic                branch_en;
   logic [PC_WIDTH-1:0] branch_target;

   // decoder port
   logic [15:0]         instr;
   logic [PC_WIDTH-1:0] instr_pc;
   logic                instr_valid;
   logic                instr_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      input  branch_en,
      input  branch_target,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      output branch_en,
      output branch_target,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the 16-bit CPU. Owns the PC, issues one
// outstanding word read at a time, buffers returned words in a small FIFO and
// hands them to the decoder over valid/ready. Branch redirects flush the FIFO
// and discard any read that is still in flight.
// Optional feature: define FETCH_COUNT_EN to add the 16-bit fetch_count output
// (number of words accepted by the decoder, wrapping).
module instr_fetch_unit #(
   parameter int                   PC_WIDTH   = 8,
   parameter int                   FIFO_DEPTH = 2,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_unit_if.master   bus
`ifdef FETCH_COUNT_EN
   ,
   output logic [15:0]          fetch_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam int                  PW      = $clog2(FIFO_DEPTH);
   localparam int                  CW      = PW + 1;
   localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

   // FSM and fetch address state
   state_t              r_state;
   state_t              w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [PC_WIDTH-1:0] r_addr;
   logic [PC_WIDTH-1:0] w_addr_nxt;
   logic                r_req;

   // prefetch FIFO
   logic [15:0]         r_mem_data [FIFO_DEPTH];
   logic [PC_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic [CW-1:0]       w_count_nxt;

   // per-edge events
   logic                w_ack;
   logic                w_pop;
   logic                w_push;
   logic                w_space;

   // An ack is only meaningful while our request is actually up.
   assign w_ack = bus.imem_ack && r_req;
   assign w_pop = (r_count != '0) && bus.instr_ready;

   // FIFO occupancy after this edge, and whether one more word would still fit.
   always_comb begin
      w_push      = (r_state == ST_WAIT) && w_ack && !bus.branch_en;
      w_count_nxt = r_count;
      if (bus.branch_en) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      end
      w_space = (w_count_nxt < DEPTH_C);
   end

   // Next-state / next-address logic; r_pc always holds the next address to
   // request, r_addr the address of the request currently (or last) on the bus.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_addr_nxt  = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (bus.branch_en) begin
               w_state_nxt = ST_WAIT;
               w_addr_nxt  = bus.branch_target;
               w_pc_nxt    = bus.branch_target + PC_ONE;
            end else if (w_space) begin
               w_state_nxt = ST_WAIT;
               w_addr_nxt  = r_pc;
               w_pc_nxt    = r_pc + PC_ONE;
            end
         end
         ST_WAIT: begin
            if (w_ack) begin
               if (bus.branch_en) begin
                  // returning word belongs to the old path; refetch at target
                  w_state_nxt = ST_WAIT;
                  w_addr_nxt  = bus.branch_target;
                  w_pc_nxt    = bus.branch_target + PC_ONE;
               end else if (w_space) begin
                  w_state_nxt = ST_WAIT;
                  w_addr_nxt  = r_pc;
                  w_pc_nxt    = r_pc + PC_ONE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (bus.branch_en) begin
               // request must complete on the old address before retargeting
               w_state_nxt = ST_DROP;
               w_pc_nxt    = bus.branch_target;
            end
         end
         ST_DROP: begin
            if (w_ack) begin
               w_state_nxt = ST_WAIT;
               if (bus.branch_en) begin
                  w_addr_nxt = bus.branch_target;
                  w_pc_nxt   = bus.branch_target + PC_ONE;
               end else begin
                  w_addr_nxt = r_pc;
                  w_pc_nxt   = r_pc + PC_ONE;
               end
            end else if (bus.branch_en) begin
               w_pc_nxt = bus.branch_target;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PC, request address and registered request strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc   <= RESET_PC;
         r_addr <= RESET_PC;
         r_req  <= 1'b0;
      end else begin
         r_pc   <= w_pc_nxt;
         r_addr <= w_addr_nxt;
         r_req  <= (w_state_nxt != ST_IDLE);
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (bus.branch_en) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
         end
      end
   end

   // FIFO storage; cleared on reset so instr/instr_pc read zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_mem_data[r_wr_ptr] <= bus.imem_rdata;
         r_mem_pc[r_wr_ptr]   <= r_addr;
      end
   end

`ifdef FETCH_COUNT_EN
   logic [15:0] r_fetch_count;

   // Count decoder pops, including a pop on a redirect edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= '0;
      end else if (w_pop) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign fetch_count = r_fetch_count;
`endif

   assign bus.imem_req    = r_req;
   assign bus.imem_addr   = r_addr;
   assign bus.instr       = r_mem_data[r_rd_ptr];
   assign bus.instr_pc    = r_mem_pc[r_rd_ptr];
   assign bus.instr_valid = (r_count != '0);

endmodule
